// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the unified memory port arbiter.
package mem_arb_pkg;
    typedef enum logic {OWN_IF, OWN_D} owner_e;
    typedef enum logic {ST_IDLE, ST_WAIT} arb_state_e;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select; MEM_ARB_RR_EN gives round-robin, otherwise data has fixed priority.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   if_req,
    input  logic   d_req,
    input  owner_e last_owner,
    output logic   win_valid,
    output owner_e win_owner
);
    assign win_valid = if_req || d_req;
`ifdef MEM_ARB_RR_EN
    // on a tie, whoever did not win last time goes next
    assign win_owner = (d_req && (!if_req || last_owner == OWN_IF)) ? OWN_D : OWN_IF;
`else
    logic unused_last;
    assign unused_last = (last_owner == OWN_D);
    assign win_owner = d_req ? OWN_D : OWN_IF;
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between fetch and load/store.
// Arbitration policy is chosen in mem_arb_pick by MEM_ARB_RR_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    localparam int CNT_W = $clog2(MEM_LAT + 1);

    arb_state_e       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    owner_e           owner, owner_n, win_owner;
    logic             win_valid, done, gnt;

    // the owner register doubles as the last-winner record for round-robin
    mem_arb_pick u_pick (
        .if_req     (if_req),
        .d_req      (d_req),
        .last_owner (owner),
        .win_valid  (win_valid),
        .win_owner  (win_owner)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            owner <= OWN_D;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            owner <= owner_n;
        end
    end

    always_comb begin
        done      = (state == ST_WAIT) && (cnt == CNT_W'(1));
        gnt       = n_rst && win_valid && (state == ST_IDLE || done);
        if_gnt    = gnt && (win_owner == OWN_IF);
        d_gnt     = gnt && (win_owner == OWN_D);
        mem_en    = gnt;
        mem_we    = d_gnt && d_we;
        mem_addr  = if_gnt ? if_addr : d_gnt ? d_addr : '0;
        mem_wdata = d_gnt ? d_wdata : '0;
        if_rvalid = done && (owner == OWN_IF);
        d_rvalid  = done && (owner == OWN_D);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = d_rvalid ? mem_rdata : '0;
        busy      = (state == ST_WAIT);
        state_n   = gnt ? ST_WAIT : done ? ST_IDLE : state;
        cnt_n     = gnt ? CNT_W'(MEM_LAT) : (state == ST_WAIT) ? cnt - CNT_W'(1) : cnt;
        owner_n   = gnt ? win_owner : owner;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of three arbiters (MEM_LAT 2, 1, 3) driven from shared requester inputs.
module tb_mem_port_arbiter;
    logic        clk = 0;
    logic        n_rst = 0;
    logic        if_req = 0, d_req = 0, d_we = 0;
    logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
    logic        if_gnt_a [3], if_rvalid_a [3], d_gnt_a [3], d_rvalid_a [3];
    logic        mem_en_a [3], mem_we_a [3], busy_a [3];
    logic [31:0] if_rdata_a [3], d_rdata_a [3], mem_addr_a [3], mem_wdata_a [3];
    int          checks = 0, errors = 0;
    logic        rr;

    always #5 clk = ~clk;

    // index 0: MEM_LAT=2, index 1: MEM_LAT=1, index 2: MEM_LAT=3
    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_port_arbiter #(.MEM_LAT(g == 0 ? 2 : g == 1 ? 1 : 3)) dut (
            .clk       (clk),
            .n_rst     (n_rst),
            .if_req    (if_req),
            .if_addr   (if_addr),
            .if_gnt    (if_gnt_a[g]),
            .if_rvalid (if_rvalid_a[g]),
            .if_rdata  (if_rdata_a[g]),
            .d_req     (d_req),
            .d_we      (d_we),
            .d_addr    (d_addr),
            .d_wdata   (d_wdata),
            .d_gnt     (d_gnt_a[g]),
            .d_rvalid  (d_rvalid_a[g]),
            .d_rdata   (d_rdata_a[g]),
            .mem_en    (mem_en_a[g]),
            .mem_we    (mem_we_a[g]),
            .mem_addr  (mem_addr_a[g]),
            .mem_wdata (mem_wdata_a[g]),
            .mem_rdata (mem_rdata),
            .busy      (busy_a[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet(input int n);
        if_req = 0;
        d_req = 0;
        d_we = 0;
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    initial begin
`ifdef MEM_ARB_RR_EN
        rr = 1;
`else
        rr = 0;
`endif
        #2;
        for (int k = 0; k < 3; k++) begin
            chk("rst_if_gnt", 32'(if_gnt_a[k]), 0);
            chk("rst_mem_en", 32'(mem_en_a[k]), 0);
            chk("rst_busy", 32'(busy_a[k]), 0);
            chk("rst_d_rvalid", 32'(d_rvalid_a[k]), 0);
        end
        next_cycle();
        n_rst = 1;
        next_cycle();

        // single fetch, MEM_LAT=2
        if_req = 1; if_addr = 32'h10; #2;
        chk("f_if_gnt", 32'(if_gnt_a[0]), 1);
        chk("f_mem_en", 32'(mem_en_a[0]), 1);
        chk("f_mem_addr", mem_addr_a[0], 32'h10);
        chk("f_mem_we", 32'(mem_we_a[0]), 0);
        next_cycle(); if_req = 0; #2;
        chk("f_busy", 32'(busy_a[0]), 1);
        chk("f_early_rvalid", 32'(if_rvalid_a[0]), 0);
        next_cycle(); mem_rdata = 32'h00500093; #2;
        chk("f_if_rvalid", 32'(if_rvalid_a[0]), 1);
        chk("f_if_rdata", if_rdata_a[0], 32'h00500093);
        chk("f_d_rvalid", 32'(d_rvalid_a[0]), 0);
        chk("f_d_rdata", d_rdata_a[0], 0);
        next_cycle(); #2;
        chk("f_idle", 32'(busy_a[0]), 0);
        chk("f_rvalid_pulse", 32'(if_rvalid_a[0]), 0);
        quiet(4);

        // single store, MEM_LAT=2
        d_req = 1; d_we = 1; d_addr = 32'h8; d_wdata = 32'hDEADBEEF; #2;
        chk("s_d_gnt", 32'(d_gnt_a[0]), 1);
        chk("s_if_gnt", 32'(if_gnt_a[0]), 0);
        chk("s_mem_en", 32'(mem_en_a[0]), 1);
        chk("s_mem_we", 32'(mem_we_a[0]), 1);
        chk("s_mem_addr", mem_addr_a[0], 32'h8);
        chk("s_mem_wdata", mem_wdata_a[0], 32'hDEADBEEF);
        next_cycle(); d_req = 0; d_we = 0; #2;
        chk("s_mem_en_off", 32'(mem_en_a[0]), 0);
        chk("s_mem_addr_off", mem_addr_a[0], 0);
        chk("s_mem_wdata_off", mem_wdata_a[0], 0);
        next_cycle(); #2;
        chk("s_d_rvalid", 32'(d_rvalid_a[0]), 1);
        chk("s_if_rvalid", 32'(if_rvalid_a[0]), 0);
        next_cycle(); #2;
        chk("s_idle", 32'(busy_a[0]), 0);
        quiet(4);

        // both requesters held for four grants; last winner is data after the store
        if_req = 1; d_req = 1; if_addr = 32'h100; d_addr = 32'h200;
        for (int c = 0; c < 8; c++) begin
            #2;
            if (c % 2 == 0) begin
                chk($sformatf("b_if_gnt_c%0d", c), 32'(if_gnt_a[0]), rr ? 32'(c % 4 == 0) : 0);
                chk($sformatf("b_d_gnt_c%0d", c), 32'(d_gnt_a[0]), rr ? 32'(c % 4 == 2) : 1);
                chk($sformatf("b_mem_addr_c%0d", c), mem_addr_a[0],
                    (rr && c % 4 == 0) ? 32'h100 : 32'h200);
            end else begin
                chk($sformatf("b_no_gnt_c%0d", c), 32'(if_gnt_a[0] | d_gnt_a[0]), 0);
            end
            next_cycle();
        end
        quiet(5);

        // back-to-back fetches, MEM_LAT=1
        if_req = 1; if_addr = 32'h40;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) if_req = 0;
            #2;
            chk($sformatf("l1_if_gnt_c%0d", c), 32'(if_gnt_a[1]), c < 3 ? 1 : 0);
            chk($sformatf("l1_if_rvalid_c%0d", c), 32'(if_rvalid_a[1]), c > 0 ? 1 : 0);
            chk($sformatf("l1_busy_c%0d", c), 32'(busy_a[1]), c > 0 ? 1 : 0);
            next_cycle();
        end
        #2;
        chk("l1_idle", 32'(busy_a[1]), 0);
        quiet(5);

        // load abandoned by reset, MEM_LAT=3
        d_req = 1; d_we = 0; d_addr = 32'h20; #2;
        chk("r_d_gnt", 32'(d_gnt_a[2]), 1);
        next_cycle(); d_req = 0; n_rst = 0; #2;
        chk("r_busy", 32'(busy_a[2]), 0);
        chk("r_mem_en", 32'(mem_en_a[2]), 0);
        chk("r_d_rvalid", 32'(d_rvalid_a[2]), 0);
        chk("r_mem_addr", mem_addr_a[2], 0);
        next_cycle(); n_rst = 1;
        for (int c = 2; c < 6; c++) begin
            #2;
            chk($sformatf("r_no_rvalid_c%0d", c), 32'(d_rvalid_a[2]), 0);
            next_cycle();
        end
        if_req = 1; if_addr = 32'h44; #2;
        chk("r_fresh_gnt", 32'(if_gnt_a[2]), 1);
        chk("r_fresh_addr", mem_addr_a[2], 32'h44);
        chk("r_fresh_idle", 32'(busy_a[2]), 0);
        next_cycle(); if_req = 0; #2;
        chk("r_fresh_busy", 32'(busy_a[2]), 1);
        quiet(6);

        // data request lands on the fetch completion cycle, MEM_LAT=2
        if_req = 1; if_addr = 32'h30; #2;
        chk("o_if_gnt", 32'(if_gnt_a[0]), 1);
        next_cycle(); if_req = 0;
        next_cycle(); d_req = 1; d_we = 0; d_addr = 32'h48; mem_rdata = 32'h1234; #2;
        chk("o_if_rvalid", 32'(if_rvalid_a[0]), 1);
        chk("o_d_gnt", 32'(d_gnt_a[0]), 1);
        chk("o_if_gnt_off", 32'(if_gnt_a[0]), 0);
        chk("o_mem_addr", mem_addr_a[0], 32'h48);
        chk("o_if_rdata", if_rdata_a[0], 32'h1234);
        chk("o_d_rdata", d_rdata_a[0], 0);
        next_cycle(); d_req = 0; mem_rdata = 32'h5678; #2;
        chk("o_busy", 32'(busy_a[0]), 1);
        chk("o_d_early", 32'(d_rvalid_a[0]), 0);
        next_cycle(); #2;
        chk("o_d_rvalid", 32'(d_rvalid_a[0]), 1);
        chk("o_d_rdata_v", d_rdata_a[0], 32'h5678);
        chk("o_if_rdata_0", if_rdata_a[0], 0);
        quiet(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
